// File: rtl/bitcount_unit.sv
// Multi-cycle CTZ / CLZ / CPOP unit scanning CHUNK bits of a WIDTH-bit operand per clock.
// Optional build macro BITCOUNT_EARLY_EXIT_EN lets CTZ/CLZ finish at the first chunk holding a set bit.
module bitcount_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int RW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    result,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int NW = $clog2(N) + 1;
  localparam int CW = $clog2(CHUNK) + 1;

`ifdef BITCOUNT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [1:0] OP_CTZ  = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic             found_q, found_d;
  logic [RW-1:0]    result_q, result_d;

  logic [NW-1:0]    idx;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    tz, lz, pop;
  logic             hit, scan, last, done_now;
  logic [RW-1:0]    acc_step;

  // Handshakes: a request transfers on a cycle with in_valid && in_ready; a result
  // transfers on a cycle with out_valid && out_ready. Both sides hold until transfer.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign dbg_state = state_q;

  // CLZ walks chunks from the top; CTZ and CPOP walk from the bottom.
  always_comb begin
    idx = (op_q == OP_CLZ) ? (NW'(N - 1) - cnt_q) : cnt_q;
    chunk = '0;
    for (int c = 0; c < N; c++) begin
      if (idx == NW'(c)) chunk = opnd_q[c*CHUNK +: CHUNK];
    end
  end

  // In-chunk counts; an all-zero chunk yields CHUNK for both tz and lz.
  always_comb begin
    tz  = CW'(CHUNK);
    lz  = CW'(CHUNK);
    pop = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) tz = CW'(i);
    end
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) lz = CW'(CHUNK - 1 - i);
      pop = pop + CW'(chunk[i]);
    end
  end

  always_comb begin
    hit  = |chunk;
    scan = (op_q == OP_CTZ) || (op_q == OP_CLZ);
    last = (cnt_q == NW'(N - 1));
    done_now = last || (EARLY && scan && hit);
    acc_step = acc_q;
    case (op_q)
      OP_CTZ:  if (!found_q) acc_step = acc_q + RW'(tz);
      OP_CLZ:  if (!found_q) acc_step = acc_q + RW'(lz);
      OP_CPOP: acc_step = acc_q + RW'(pop);
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    found_d  = found_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          opnd_d  = operand;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          found_d = 1'b0;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_step;
          found_d = found_q | (scan & hit);
          cnt_d   = cnt_q + NW'(1);
          if (done_now) begin
            state_d  = DONE;
            result_d = (op_q == 2'b11) ? '0 : acc_step;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      found_q  <= found_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_bitcount_unit.sv
// Directed bench for bitcount_unit (WIDTH=32, CHUNK=8): queued expectations, decoupled monitor.
module tb_bitcount_unit;

  localparam int W  = 32;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  operand = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] result;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            e0 = 0;
  bit            ov_seen = 1'b0;

  bitcount_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat(input int early, input int full);
`ifdef BITCOUNT_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  // Monitor: latency on the first valid cycle, result on the handshake cycle.
  always @(negedge clk) begin
    if (!rst) begin
      ov_seen = 1'b0;
    end else if (out_valid) begin
      if (!ov_seen) begin
        ov_seen = 1'b1;
        if (lat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid: got 1 expected 0");
        end else begin
          check("latency", cyc - e0, lat_q.pop_front());
        end
      end
      if (out_ready) begin
        ov_seen = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got %0d expected none", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic issue(input logic [1:0] o, input logic [31:0] d);
    in_valid = 1'b1;
    op = o;
    operand = d;
    @(posedge clk); #1;
    e0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid_low"}, out_valid, 0);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                        input logic [RW-1:0] r, input int l);
    exp_q.push_back(r);
    lat_q.push_back(l);
    issue(o, d);
    drain(name);
  endtask

  initial begin
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    run_op("ctz_0100",   2'b00, 32'h0000_0100, 6'd8,  lat(2, 4));
    run_op("clz_0001",   2'b01, 32'h0000_0001, 6'd31, lat(4, 4));
    run_op("clz_8000",   2'b01, 32'h8000_0000, 6'd0,  lat(1, 4));
    run_op("cpop_f0f0",  2'b10, 32'hF0F0_F0F0, 6'd16, 4);
    run_op("cpop_ffff",  2'b10, 32'hFFFF_FFFF, 6'd32, 4);
    run_op("ctz_zero",   2'b00, 32'h0000_0000, 6'd32, 4);
    run_op("clz_zero",   2'b01, 32'h0000_0000, 6'd32, 4);
    run_op("cpop_zero",  2'b10, 32'h0000_0000, 6'd0,  4);
    run_op("rsv_1234",   2'b11, 32'h0000_1234, 6'd0,  4);
    run_op("ctz_ones",   2'b00, 32'hFFFF_FFFF, 6'd0,  lat(1, 4));
    run_op("clz_ones",   2'b01, 32'hFFFF_FFFF, 6'd0,  lat(1, 4));
    run_op("ctz_8000",   2'b00, 32'h8000_0000, 6'd31, lat(4, 4));
    run_op("clz_10000",  2'b01, 32'h0001_0000, 6'd15, lat(2, 4));
    run_op("ctz_f00000", 2'b00, 32'h00F0_0000, 6'd20, lat(3, 4));

    // Back-pressure: result held, stray requests ignored.
    out_ready = 1'b0;
    exp_q.push_back(6'd8);
    lat_q.push_back(4);
    issue(2'b10, 32'h0000_00FF);
    in_valid = 1'b1;
    operand = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("hold_busy", busy, 1);
    check("hold_in_ready_busy", in_ready, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("hold_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 8);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drain("hold_release");

    // Abort while busy: no result, previous result kept.
    issue(2'b10, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    abort = 1'b1;
    check("abort_busy_before", busy, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", in_ready, 1);
    check("abort_busy_after", busy, 0);
    check("abort_result_kept", result, 8);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_out_valid", out_valid, 0);

    // Abort in IDLE is harmless.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    run_op("after_abort", 2'b00, 32'h0000_0100, 6'd8, lat(2, 4));

    // Asynchronous reset mid-operation.
    issue(2'b10, 32'hFFFF_FFFF);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 2'b10, 32'hF0F0_F0F0, 6'd16, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
